// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game of Life edit controller.
// Optional auto-repeat of cursor buttons is enabled with the GOL_AUTOREPEAT_EN macro.
package gol_pkg;

    localparam int GRID_W_DEF = 16;
    localparam int GRID_H_DEF = 16;
    localparam int NUM_BTN    = 7;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } edit_state_t;

    // Packed so that bit 0 is left and bit 6 is clear, matching the raw button vector.
    typedef struct packed {
        logic clear;
        logic run;
        logic toggle;
        logic down;
        logic up;
        logic right;
        logic left;
    } btn_evt_t;

    function automatic int unsigned cell_idx(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/gol_debounce.sv
// One button: 2-FF synchroniser, debounce counter and registered rising-edge event.
// The first settled level after reset is adopted silently, so a button held through reset gives no event.
module gol_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        rise_q, rise_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  fill_q, fill_d;
    logic        ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
            fill_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
        end
    end

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        fill_d  = fill_q;
        ready_d = ready_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (!ready_q) begin
            if (fill_q == 2'd2) begin
                level_d = sync2_q;
                ready_d = 1'b1;
            end else begin
                fill_d = fill_q + 2'd1;
            end
        end else if (sync2_q != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/gol_edit_ctrl.sv
// Run/pause control, cursor movement and cell editing in front of the Game of Life core.
// Define GOL_AUTOREPEAT_EN to make held direction buttons auto-repeat.
module gol_edit_ctrl
    import gol_pkg::*;
#(
    parameter int          GRID_W          = GRID_W_DEF,
    parameter int          GRID_H          = GRID_H_DEF,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd10000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_toggle,
    input  logic                        btn_run,
    input  logic                        btn_clear,
    input  logic [GRID_W*GRID_H-1:0]    grid_live,
    output logic [GRID_W*GRID_H-1:0]    grid_edit,
    output logic                        paused,
    output logic [$clog2(GRID_W)-1:0]   sel_x,
    output logic [$clog2(GRID_H)-1:0]   sel_y,
    output logic                        cell_alive,
    output logic                        edit_pulse
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int IW    = $clog2(NCELL);

    logic [NUM_BTN-1:0] btn_raw, btn_level, btn_rise;
    btn_evt_t           press_evt, evt;
    logic [3:0]         dir_rise, dir_evt;

    assign btn_raw = {btn_clear, btn_run, btn_toggle, btn_down, btn_up, btn_right, btn_left};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        gol_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .rise (btn_rise[g])
        );
    end

    assign press_evt = btn_evt_t'(btn_rise & btn_level);
    assign dir_rise  = {press_evt.down, press_evt.up, press_evt.right, press_evt.left};

`ifdef GOL_AUTOREPEAT_EN
    logic [23:0] rep_cnt_q [4];
    logic [23:0] rep_cnt_d [4];
    logic [3:0]  rep_arm_q, rep_arm_d, rep_fire;
    logic [3:0]  dir_level;

    assign dir_level = btn_level[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
            rep_arm_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) rep_cnt_q[i] <= rep_cnt_d[i];
            rep_arm_q <= rep_arm_d;
        end
    end

    // rep_arm marks that the initial hold delay has elapsed and the shorter period now applies.
    always_comb begin
        rep_arm_d = rep_arm_q;
        rep_fire  = '0;
        for (int i = 0; i < 4; i++) begin
            rep_cnt_d[i] = '0;
            if (dir_rise[i]) begin
                rep_arm_d[i] = 1'b0;
            end else if (dir_level[i]) begin
                if (!rep_arm_q[i] && rep_cnt_q[i] == REPEAT_DELAY - 24'd1) begin
                    rep_fire[i]  = 1'b1;
                    rep_arm_d[i] = 1'b1;
                end else if (rep_arm_q[i] && rep_cnt_q[i] == REPEAT_PERIOD - 24'd1) begin
                    rep_fire[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 24'd1;
                end
            end else begin
                rep_arm_d[i] = 1'b0;
            end
        end
    end

    assign dir_evt = dir_rise | rep_fire;
`else
    assign dir_evt = dir_rise;
`endif

    always_comb begin
        evt = press_evt;
        {evt.down, evt.up, evt.right, evt.left} = dir_evt;
    end

    edit_state_t       state_q, state_d;
    logic [NCELL-1:0]  grid_q, grid_d;
    logic [XW-1:0]     sel_x_q, sel_x_d;
    logic [YW-1:0]     sel_y_q, sel_y_d;
    logic              pulse_q, pulse_d;
    logic [IW-1:0]     cur_idx;
    logic [NCELL-1:0]  cur_mask;

    assign cur_idx  = IW'(cell_idx(32'(sel_x_q), 32'(sel_y_q), 32'(GRID_W)));
    assign cur_mask = {{(NCELL-1){1'b0}}, 1'b1} << cur_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            grid_q  <= '0;
            sel_x_q <= '0;
            sel_y_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            sel_x_q <= sel_x_d;
            sel_y_q <= sel_y_d;
            pulse_q <= pulse_d;
        end
    end

    // Only the highest-priority event class acts; the two move axes are independent.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        sel_x_d = sel_x_q;
        sel_y_d = sel_y_q;
        pulse_d = 1'b0;
        if (evt.clear) begin
            grid_d  = '0;
            pulse_d = 1'b1;
            state_d = PAUSED;
        end else if (evt.run) begin
            if (state_q == PAUSED) begin
                state_d = RUN;
            end else begin
                state_d = PAUSED;
                grid_d  = grid_live;
                pulse_d = 1'b1;
            end
        end else if (state_q == PAUSED) begin
            if (evt.toggle) begin
                grid_d  = grid_q ^ cur_mask;
                pulse_d = 1'b1;
            end else begin
                if (evt.right && !evt.left) begin
                    sel_x_d = (sel_x_q == XW'(GRID_W - 1)) ? '0 : sel_x_q + XW'(1);
                end else if (evt.left && !evt.right) begin
                    sel_x_d = (sel_x_q == '0) ? XW'(GRID_W - 1) : sel_x_q - XW'(1);
                end
                if (evt.down && !evt.up) begin
                    sel_y_d = (sel_y_q == YW'(GRID_H - 1)) ? '0 : sel_y_q + YW'(1);
                end else if (evt.up && !evt.down) begin
                    sel_y_d = (sel_y_q == '0) ? YW'(GRID_H - 1) : sel_y_q - YW'(1);
                end
            end
        end
    end

    always_comb begin
        paused     = (state_q == PAUSED);
        grid_edit  = grid_q;
        sel_x      = sel_x_q;
        sel_y      = sel_y_q;
        cell_alive = grid_q[cur_idx];
        edit_pulse = pulse_q;
    end

endmodule

// File: tb/tb_gol_edit_ctrl.sv
// Self-checking bench for gol_edit_ctrl: directed scenarios then random presses against a cell/cursor model.
// Define GOL_AUTOREPEAT_EN to also exercise the auto-repeat scenario.
module tb_gol_edit_ctrl;

    localparam int          GW   = 16;
    localparam int          GH   = 16;
    localparam int          NC   = GW * GH;
    localparam logic [19:0] DB   = 20'd4;
    localparam int          HOLD = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_left, btn_right, btn_up, btn_down, btn_toggle, btn_run, btn_clear;
    logic [NC-1:0] grid_live, grid_edit;
    logic          paused, cell_alive, edit_pulse;
    logic [3:0]    sel_x, sel_y;

    int            testsRun = 0;
    int            testsFailed = 0;
    int            pulseCnt = 0;
    int            doublePulse = 0;
    bit            prevPulse = 1'b0;

    int            mx, my, expPulse;
    bit            mpaused;
    logic [NC-1:0] mgrid;

    always #5 clk = ~clk;

    gol_edit_ctrl #(
        .GRID_W         (GW),
        .GRID_H         (GH),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_toggle(btn_toggle),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .grid_live (grid_live),
        .grid_edit (grid_edit),
        .paused    (paused),
        .sel_x     (sel_x),
        .sel_y     (sel_y),
        .cell_alive(cell_alive),
        .edit_pulse(edit_pulse)
    );

    always @(posedge clk) begin
        #1;
        if (edit_pulse) begin
            pulseCnt++;
            if (prevPulse) doublePulse++;
        end
        prevPulse = edit_pulse;
    end

    task automatic checkOutput(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mask bits: 0 left, 1 right, 2 up, 3 down, 4 toggle, 5 run, 6 clear.
    task automatic setButtons(input logic [6:0] m);
        {btn_clear, btn_run, btn_toggle, btn_down, btn_up, btn_right, btn_left} = m;
    endtask

    task automatic modelApply(input logic [6:0] m);
        expPulse = 0;
        if (m[6]) begin
            mgrid    = '0;
            mpaused  = 1'b1;
            expPulse = 1;
        end else if (m[5]) begin
            if (mpaused) begin
                mpaused = 1'b0;
            end else begin
                mpaused  = 1'b1;
                mgrid    = grid_live;
                expPulse = 1;
            end
        end else if (mpaused) begin
            if (m[4]) begin
                mgrid[my*GW+mx] = ~mgrid[my*GW+mx];
                expPulse = 1;
            end else begin
                mx = (mx + int'(m[1]) - int'(m[0]) + GW) % GW;
                my = (my + int'(m[3]) - int'(m[2]) + GH) % GH;
            end
        end
    endtask

    task automatic applyStimulus(input logic [6:0] m);
        pulseCnt = 0;
        setButtons(m);
        repeat (HOLD) @(negedge clk);
        setButtons(7'd0);
        repeat (HOLD) @(negedge clk);
        modelApply(m);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_selx"},   NC'(sel_x),      NC'(mx));
        checkOutput({tag, "_sely"},   NC'(sel_y),      NC'(my));
        checkOutput({tag, "_paused"}, NC'(paused),     NC'(mpaused));
        checkOutput({tag, "_grid"},   grid_edit,       mgrid);
        checkOutput({tag, "_alive"},  NC'(cell_alive), NC'(mgrid[my*GW+mx]));
        checkOutput({tag, "_pulses"}, NC'(pulseCnt),   NC'(expPulse));
    endtask

    initial begin
        int lat;
        logic [6:0] m;

        rst_n     = 1'b0;
        setButtons(7'd0);
        btn_right = 1'b1;
        grid_live = '0;
        mx = 0; my = 0; mpaused = 1'b1; mgrid = '0; expPulse = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_paused", NC'(paused), NC'(1));
        checkOutput("rst_selx",   NC'(sel_x),  '0);
        checkOutput("rst_sely",   NC'(sel_y),  '0);
        checkOutput("rst_grid",   grid_edit,   '0);
        checkOutput("rst_pulse",  NC'(edit_pulse), '0);
        rst_n = 1'b1;
        repeat (DB + 10) @(negedge clk);
        checkOutput("held_through_reset", NC'(sel_x), '0);
        btn_right = 1'b0;
        repeat (HOLD) @(negedge clk);

        pulseCnt = 0;
        for (int i = 0; i < 10; i++) begin
            btn_right = logic'((i / 2) % 2);
            @(negedge clk);
        end
        checkOutput("bounce_no_move", NC'(sel_x), '0);
        btn_right = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (sel_x == 4'd1) lat = k;
        end
        checkOutput("bounce_latency", NC'(lat), NC'(7));
        repeat (HOLD) @(negedge clk);
        btn_right = 1'b0;
        repeat (HOLD) @(negedge clk);
        mx = 1;
        checkAll("bounce");

        applyStimulus(7'b0000001); checkAll("left1");
        applyStimulus(7'b0000001); checkAll("left_wrap");
        applyStimulus(7'b0000100); checkAll("up_wrap");
        checkOutput("wrap_corner", NC'({sel_x, sel_y}), NC'(8'hFF));
        applyStimulus(7'b0000010); checkAll("right_wrap");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'b0001010); checkAll("diag");
        end
        checkOutput("at_3_2", NC'({sel_x, sel_y}), NC'(8'h32));
        applyStimulus(7'b0010000); checkAll("toggle_on");
        checkOutput("bit35_on", NC'(grid_edit[35]), NC'(1));
        applyStimulus(7'b0010000); checkAll("toggle_off");
        checkOutput("bit35_off", NC'(grid_edit[35]), '0);
        applyStimulus(7'b0000011); checkAll("lr_cancel");
        applyStimulus(7'b0010010); checkAll("toggle_beats_move");

`ifdef GOL_AUTOREPEAT_EN
        pulseCnt  = 0;
        btn_right = 1'b1;
        repeat (38) @(negedge clk);
        btn_right = 1'b0;
        repeat (HOLD) @(negedge clk);
        mx = (mx + 5) % GW;
        expPulse = 0;
        checkAll("autorepeat");
`endif

        applyStimulus(7'b0100000); checkAll("run");
        applyStimulus(7'b0010000); checkAll("run_toggle_ignored");
        applyStimulus(7'b0000010); checkAll("run_move_ignored");
        grid_live = {16{16'hA5A5}};
        applyStimulus(7'b0100000); checkAll("pause_capture");
        checkOutput("capture_live", grid_edit, grid_live);
        applyStimulus(7'b0100000); checkAll("run2");
        applyStimulus(7'b1010000); checkAll("clear_beats_toggle");

        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < NC / 32; w++) grid_live[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) m = 7'(1 << $urandom_range(0, 6));
            else m = 7'($urandom_range(0, 127));
            applyStimulus(m);
            checkAll("random");
        end

        checkOutput("no_double_pulse", NC'(doublePulse), '0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gol_edit_ctrl.md
Name: gol_edit_ctrl

Overview:
- Upstream control stage of the Game of Life core.
- Conditions raw board buttons: 2-FF synchroniser, debounce, rising-edge detect.
- Runs the run/pause state machine, moves the edit cursor with wrap-around, and toggles cells in an edit copy of the grid.
- Drives the core with the edited grid, the paused flag, the cursor position, and a one-cycle "grid changed" strobe.

Parameters:
- GRID_W, 16, grid columns (>=2)
- GRID_H, 16, grid rows (>=2)
- DEBOUNCE_CYCLES, 20'd500000, stable-level cycles before a button change is accepted (>=2)
- REPEAT_DELAY, 24'd10000000, hold time before auto-repeat starts (feature only)
- REPEAT_PERIOD, 24'd2500000, auto-repeat interval (feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_left, btn_right, btn_up, btn_down  in  1 each  raw cursor buttons, active-high, asynchronous
- btn_toggle  in  1  raw toggle-selected-cell button
- btn_run  in  1  raw start/stop button
- btn_clear  in  1  raw clear-grid button
- grid_live  in  GRID_W*GRID_H  current evolved grid from core; bit index y*GRID_W+x
- grid_edit  out  GRID_W*GRID_H  edited grid presented to core
- paused  out  1  1 = simulation halted
- sel_x  out  $clog2(GRID_W)  cursor column
- sel_y  out  $clog2(GRID_H)  cursor row
- cell_alive  out  1  grid_edit bit at cursor (combinational from registers)
- edit_pulse  out  1  one-cycle strobe when grid_edit changes

Behaviour:
- Reset, asynchronous on rst_n low:
  - grid_edit=0, paused=1, sel_x=0, sel_y=0, edit_pulse=0, state=PAUSED.
  - All synchronisers, debounce counters and edge detectors are cleared; a button held through reset produces no event after release of reset.
- Button conditioning, per button:
  - 2-FF synchroniser feeds a debounce counter.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce.
  - Event = one-cycle pulse on a debounced 0->1 edge. Latency from a clean press is 2+DEBOUNCE_CYCLES+1 cycles.
- States:
  - PAUSED: edits allowed.
  - RUN: edits ignored.
- PAUSED -> RUN on run event: paused<=0 next cycle; grid_edit unchanged.
- RUN -> PAUSED on run event: paused<=1, grid_edit<=grid_live sampled that same cycle, edit_pulse=1 for one cycle.
- Clear event in either state:
  - grid_edit<=0, edit_pulse=1, state=PAUSED, paused=1.
  - Cursor unchanged.
- Move events, PAUSED only:
  - right: sel_x = (sel_x==GRID_W-1) ? 0 : sel_x+1.
  - left: sel_x = (sel_x==0) ? GRID_W-1 : sel_x-1.
  - down: sel_y = (sel_y==GRID_H-1) ? 0 : sel_y+1.
  - up: sel_y = (sel_y==0) ? GRID_H-1 : sel_y-1.
  - In RUN, moves are discarded, not queued.
- Toggle event, PAUSED only: invert grid_edit[sel_y*GRID_W+sel_x]; edit_pulse=1.
- Simultaneous events in one cycle, priority clear > run > toggle > moves:
  - Only the highest-priority class executes; lower events are dropped.
  - Exception: left+up or right+down etc. on different axes both apply in the same cycle; opposite directions on one axis cancel.
  - Toggle in the same cycle as a move uses the pre-move cursor, and the move is dropped per priority.
- edit_pulse is never asserted for two consecutive cycles from a single event.
- Non-power-of-two GRID_W/GRID_H: the cursor never exceeds GRID_W-1/GRID_H-1.

Optional Feature:
- Macro GOL_AUTOREPEAT_EN.
- When defined: a direction button whose debounced level stays high generates its first move event on the edge, then a further event after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until release. Toggle, run and clear never repeat.
- When undefined: exactly one move per press; the repeat counters and parameters are unused and synthesise away.

Decomposition:
- Package gol_pkg holds:
  - GRID_W/GRID_H default localparams
  - typedef enum logic {PAUSED, RUN} edit_state_t
  - typedef struct btn_evt_t {left, right, up, down, toggle, run, clear}
  - function cell_idx(x,y)
- Sub-module gol_debounce (params DEBOUNCE_CYCLES; ports clk, rst_n, raw, level, rise), instantiated 7 times.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset: rst_n low 3 cycles with btn_right held -> paused=1, sel=(0,0), grid_edit=0; releasing rst_n with the button still high gives no move.
- Bounce: btn_right pulses 0/1 every 2 cycles for 10 cycles, then stable 1 -> exactly one move, sel_x=1, arriving 7 cycles after the stable start.
- Wrap: from (0,0) press left, then up -> sel=(15,15); press right -> sel=(0,15).
- Toggle: at (3,2) press toggle -> grid_edit bit 35 = 1, edit_pulse high exactly 1 cycle, cell_alive=1; second toggle -> bit 35 = 0.
- Run/pause capture: run -> paused=0; toggle and right ignored; force grid_live=16'hA5A5 pattern; run -> paused=1, grid_edit==grid_live, edit_pulse=1.
- Priority: clear and toggle events in the same cycle while in RUN -> grid_edit=0, paused=1, no toggle; with GOL_AUTOREPEAT_EN (REPEAT_DELAY=20, REPEAT_PERIOD=5), holding right 40 cycles -> sel_x increments at edge, +20, +25, +30, +35.
